// File: rtl/nq_alu_pkg.sv
// Shared opcode/funct codes, FSM state type and immediate helper for the NanoQuarter execute unit.
package nq_alu_pkg;

    localparam logic [1:0] OP_R = 2'b00;
    localparam logic [1:0] OP_I = 2'b01;

    localparam logic [4:0] C_NAND = 5'b00_000;
    localparam logic [4:0] C_XOR  = 5'b00_001;
    localparam logic [4:0] C_SLL  = 5'b00_010;
    localparam logic [4:0] C_SRL  = 5'b00_011;
    localparam logic [4:0] C_SRA  = 5'b00_100;
    localparam logic [4:0] C_ADD  = 5'b00_101;
    localparam logic [4:0] C_SUB  = 5'b00_110;
    localparam logic [4:0] C_MUL  = 5'b00_111;
    localparam logic [4:0] C_LUI  = 5'b01_000;
    localparam logic [4:0] C_LBI  = 5'b01_001;
    localparam logic [4:0] C_SUI  = 5'b01_010;
    localparam logic [4:0] C_SBI  = 5'b01_011;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    // Upper-half placement of the immediate (LUI/SUI); otherwise it lands in the low half.
    function automatic logic imm_upper(input logic [4:0] code);
        return (code == C_LUI) || (code == C_SUI);
    endfunction

endpackage

// File: rtl/nq_mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of the product.
module nq_mul_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done_c,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;

    // High during the final iteration, so the product is complete on the following edge.
    assign done_c = busy && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            product  <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            product  <= '0;
        end else if (busy) begin
            if (mplier_q[0]) begin
                product <= product + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/nq_alu_seq.sv
// NanoQuarter execute unit: registered ALU with valid/ready on both sides.
// Define NQ_ALU_MUL_EN to build the multi-cycle MUL path; otherwise MUL decodes as illegal.
module nq_alu_seq
    import nq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 2,
    parameter int unsigned IMMW  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [2:0]       funct,
    input  logic [SHW-1:0]   shamt,
    input  logic [IMMW-1:0]  idata,
    input  logic [WIDTH-1:0] reg1data,
    input  logic [WIDTH-1:0] reg2data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUout,
    output logic             illegal
);

    localparam int unsigned LW = $clog2(WIDTH);

    logic [4:0]       code_c;
    logic [LW-1:0]    samt_c;
    logic [WIDTH-1:0] rt_c;
    logic [WIDTH-1:0] res_c;
    logic             ill_c;
    logic             is_mul_c;
    logic             out_free_c;
    logic             accept_c;
    logic             mul_load_c;
    logic             load_c;
    logic [WIDTH-1:0] load_data_c;

    assign code_c     = {op, funct};
    assign samt_c     = reg2data[LW-1:0];
    assign out_free_c = !out_valid || out_ready;
    assign accept_c   = in_valid && in_ready;

    // Single-cycle decode and result formation.
    always_comb begin
        rt_c     = '0;
        res_c    = '0;
        ill_c    = 1'b0;
        is_mul_c = 1'b0;
        case (code_c)
            C_NAND: rt_c = ~(reg1data & reg2data);
            C_XOR:  rt_c = reg1data ^ reg2data;
            C_SLL:  rt_c = reg1data << samt_c;
            C_SRL:  rt_c = reg1data >> samt_c;
            C_SRA:  rt_c = WIDTH'($signed(reg1data) >>> samt_c);
            C_ADD:  rt_c = reg1data + reg2data;
            C_SUB:  rt_c = reg1data - reg2data;
`ifdef NQ_ALU_MUL_EN
            C_MUL:  is_mul_c = 1'b1;
`else
            C_MUL:  ill_c = 1'b1;
`endif
            C_LUI, C_LBI, C_SUI, C_SBI: begin
                res_c = imm_upper(code_c) ? WIDTH'({idata, {IMMW{1'b0}}})
                                          : WIDTH'({{IMMW{1'b0}}, idata});
            end
            default: ill_c = 1'b1;
        endcase
        if (op == OP_R) begin
            res_c = rt_c << shamt;
        end
    end

`ifdef NQ_ALU_MUL_EN
    state_t           state_q;
    state_t           state_d;
    logic             mul_start_c;
    logic             mul_busy;
    logic             mul_done_c;
    logic [WIDTH-1:0] mul_prod;
    logic [SHW-1:0]   mul_shamt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mul_shamt_q <= '0;
        end else begin
            state_q <= state_d;
            if (mul_start_c) begin
                mul_shamt_q <= shamt;
            end
        end
    end

    // Issue side is held off for the whole MUL, including while a finished product waits in DONE.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        mul_start_c = 1'b0;
        mul_load_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = out_free_c;
                if (in_valid && out_free_c && is_mul_c) begin
                    mul_start_c = 1'b1;
                    state_d     = ST_MUL_BUSY;
                end
            end
            ST_MUL_BUSY: begin
                if (mul_busy && mul_done_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_free_c) begin
                    mul_load_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    nq_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_c),
        .a       (reg1data),
        .b       (reg2data),
        .busy    (mul_busy),
        .done_c  (mul_done_c),
        .product (mul_prod)
    );

    assign load_data_c = mul_load_c ? (mul_prod << mul_shamt_q) : res_c;
`else
    assign in_ready    = out_free_c;
    assign mul_load_c  = 1'b0;
    assign load_data_c = res_c;
`endif

    assign load_c = (accept_c && !is_mul_c) || mul_load_c;

    // Output register: a new load takes priority over retiring the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ALUout    <= '0;
            illegal   <= 1'b0;
        end else if (load_c) begin
            out_valid <= 1'b1;
            ALUout    <= load_data_c;
            illegal   <= ill_c && !mul_load_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
